border_mask_stats: RTL and testbench

BORDER_MASK_STATS -- requirements
Module: border_mask_stats

---
 rtl/img_pkg.sv | 24 ++
 rtl/dstream.sv | 11 +
 rtl/skid_fifo2.sv | 63 ++++++
 rtl/border_mask_stats.sv | 98 +++++++++
 tb/tb_border_mask_stats.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: frame geometry, channel packing and luma.
package img_pkg;

    localparam int IMG_WIDTH  = 320;
    localparam int IMG_HEIGHT = 240;

    localparam int R_HI = 29;
    localparam int R_LO = 22;
    localparam int G_HI = 19;
    localparam int G_LO = 12;
    localparam int B_HI = 9;
    localparam int B_LO = 2;

    localparam int LUMA_W = 8;
    localparam int SUM_W  = 25;

    // (R + 2G + B) >> 2; the 10-bit intermediate holds the worst case of 1020.
    function automatic logic [LUMA_W-1:0] luma_of(input logic [29:0] px);
        logic [9:0] s;
        s = {2'b00, px[R_HI:R_LO]} + {1'b0, px[G_HI:G_LO], 1'b0} + {2'b00, px[B_HI:B_LO]};
        return LUMA_W'(s >> 2);
    endfunction

endpackage

// File: rtl/dstream.sv
// Valid/ready pixel stream between pipeline stages.
interface dstream #(
    parameter int W = 30
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport in  (input valid, input data, output ready);
    modport out (output valid, output data, input ready);
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry stream FIFO: ready while not full, head presented directly on y.
module skid_fifo2 #(
    parameter int W = 30
) (
    input  logic clk,
    input  logic rst_n,
    dstream.in   x,
    dstream.out  y
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push;
    logic         pop;

    assign x.ready = (cnt_q != 2'd2);
    assign y.valid = (cnt_q != 2'd0);
    assign y.data  = head_q;

    assign push = x.valid & x.ready;
    assign pop  = y.valid & y.ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) head_d = x.data;
                else               tail_d = x.data;
            end
            2'b01: begin
                cnt_d  = cnt_q - 2'd1;
                head_d = tail_q;
            end
            2'b11: begin
                // Push while full cannot happen, so occupancy is 1 or 2 here.
                if (cnt_q == 2'd1) begin
                    head_d = x.data;
                end else begin
                    head_d = tail_q;
                    tail_d = x.data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/border_mask_stats.sv
// Masks the blur-window border of each frame to FILL and accumulates the
// interior luma sum, reported once per frame.
module border_mask_stats
    import img_pkg::*;
#(
    parameter int           W      = 30,
    parameter int           WIDTH  = IMG_WIDTH,
    parameter int           HEIGHT = IMG_HEIGHT,
    parameter int           BORDER = 2,
    parameter logic [W-1:0] FILL   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    dstream.in               x,
    dstream.out              y,
    output logic             frame_done,
    output logic [SUM_W-1:0] luma_sum
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] luma_sum_q, luma_sum_d;
    logic             frame_done_q, frame_done_d;
    logic             accept;
    logic             is_border;
    logic             last_col;
    logic             last_px;

    dstream #(.W(W)) mx ();

    assign accept    = x.valid & x.ready;
    assign last_col  = (col_q == CW'(WIDTH - 1));
    assign last_px   = last_col && (row_q == RW'(HEIGHT - 1));
    assign is_border = (col_q <  CW'(BORDER))
                    || (col_q >= CW'(WIDTH - BORDER))
                    || (row_q <  RW'(BORDER))
                    || (row_q >= RW'(HEIGHT - BORDER));

    // The FIFO's ready is the only backpressure, so acceptance here and the
    // FIFO push are the same event.
    assign mx.valid = x.valid;
    assign mx.data  = is_border ? FILL : x.data;
    assign x.ready  = mx.ready;

    skid_fifo2 #(.W(W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (mx),
        .y     (y)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        acc_d        = acc_q;
        luma_sum_d   = luma_sum_q;
        frame_done_d = 1'b0;
        if (accept) begin
            if (!is_border) acc_d = acc_q + SUM_W'(luma_of(x.data));
            if (last_col) begin
                col_d = '0;
                row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            // The last pixel is always border, so acc_q is already the full frame.
            if (last_px) begin
                frame_done_d = 1'b1;
                luma_sum_d   = acc_q;
                acc_d        = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            luma_sum_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            luma_sum_q   <= luma_sum_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;
    assign luma_sum   = luma_sum_q;

endmodule

// File: tb/tb_border_mask_stats.sv
// Scoreboard bench: a full default-size frame on one instance, and a small
// 16x12 instance for backpressure, multi-frame and mid-frame reset scenarios.
module tb_border_mask_stats;
    import img_pkg::*;

    localparam int          SW    = 16;
    localparam int          SH    = 12;
    localparam int          BRD   = 2;
    localparam logic [29:0] SFILL = 30'h2AAAAAAA;

    typedef struct packed {
        logic [29:0] data;
        int          col;
        int          row;
    } ent_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic rst_s = 1'b0;
    always #5 clk = ~clk;

    dstream #(.W(30)) xb ();
    dstream #(.W(30)) yb ();
    dstream #(.W(30)) xs ();
    dstream #(.W(30)) ys ();
    logic        fd_b, fd_s;
    logic [24:0] ls_b, ls_s;

    border_mask_stats u_big (
        .clk(clk), .rst_n(rst_b), .x(xb), .y(yb), .frame_done(fd_b), .luma_sum(ls_b)
    );

    border_mask_stats #(.WIDTH(SW), .HEIGHT(SH), .BORDER(BRD), .FILL(SFILL)) u_sml (
        .clk(clk), .rst_n(rst_s), .x(xs), .y(ys), .frame_done(fd_s), .luma_sum(ls_s)
    );

    logic        xv[2], xr[2], yv[2], yr[2], fdv[2], rstv[2];
    logic [29:0] xd[2], yd[2];
    logic [24:0] lsv[2];
    assign xv[0] = xb.valid;  assign xv[1] = xs.valid;
    assign xr[0] = xb.ready;  assign xr[1] = xs.ready;
    assign xd[0] = xb.data;   assign xd[1] = xs.data;
    assign yv[0] = yb.valid;  assign yv[1] = ys.valid;
    assign yr[0] = yb.ready;  assign yr[1] = ys.ready;
    assign yd[0] = yb.data;   assign yd[1] = ys.data;
    assign fdv[0] = fd_b;     assign fdv[1] = fd_s;
    assign lsv[0] = ls_b;     assign lsv[1] = ls_s;
    assign rstv[0] = rst_b;   assign rstv[1] = rst_s;

    int     nvec = 0;
    int     nerr = 0;
    longint cyc = 0;
    ent_t   q0[$];
    ent_t   q1[$];
    int     mcol[2], mrow[2], macc[2], mlsum[2], lexp[2], occ[2];
    int     acc_cnt[2], fd_cnt[2];
    longint fd_cyc[2];
    int     corner_hits = 0;
    int     rk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r, 2'b00, g, 2'b00, b, 2'b00};
    endfunction

    function automatic logic [29:0] gen(input int mode, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        case (mode)
            0:       return pix(kk, 8'(k * 3), ~kk);
            1:       return pix(8'hFF, 8'hFF, 8'hFF);
            default: return '0;
        endcase
    endfunction

    function automatic int pw(input int d);
        return (d == 0) ? 320 : SW;
    endfunction

    function automatic int ph(input int d);
        return (d == 0) ? 240 : SH;
    endfunction

    function automatic logic [29:0] fillv(input int d);
        return (d == 0) ? 30'h0 : SFILL;
    endfunction

    // Input side: track occupancy, predict the masked pixel for each accepted beat.
    task automatic in_mon(input int d);
        ent_t e;
        if (!rstv[d]) begin
            mcol[d] = 0; mrow[d] = 0; macc[d] = 0; occ[d] = 0; fd_cyc[d] = -1;
            if (d == 0) q0.delete(); else q1.delete();
            return;
        end
        check($sformatf("x_ready_d%0d", d), 64'(xr[d]), 64'(occ[d] < 2));
        check($sformatf("y_valid_d%0d", d), 64'(yv[d]), 64'(occ[d] > 0));
        if (xv[d] && xr[d]) begin
            e.col = mcol[d];
            e.row = mrow[d];
            if (mcol[d] < BRD || mcol[d] >= pw(d) - BRD || mrow[d] < BRD || mrow[d] >= ph(d) - BRD) begin
                e.data = fillv(d);
            end else begin
                e.data = xd[d];
                macc[d] += (int'(xd[d][29:22]) + 2 * int'(xd[d][19:12]) + int'(xd[d][9:2])) / 4;
            end
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            acc_cnt[d]++;
            occ[d]++;
            if (mcol[d] == pw(d) - 1) begin
                mcol[d] = 0;
                if (mrow[d] == ph(d) - 1) begin
                    mrow[d]   = 0;
                    fd_cyc[d] = cyc + 1;
                    lexp[d]   = macc[d];
                    macc[d]   = 0;
                end else begin
                    mrow[d]++;
                end
            end else begin
                mcol[d]++;
            end
        end
        if (yv[d] && yr[d]) occ[d]--;
    endtask

    // Output side: pop and compare presented pixels, frame_done and luma_sum.
    task automatic out_mon(input int d);
        ent_t        e;
        bit          fdx;
        logic [29:0] cexp;
        if (!rstv[d]) begin
            mlsum[d] = 0;
            check($sformatf("rst_y_valid_d%0d", d), 64'(yv[d]), 64'(0));
            check($sformatf("rst_y_data_d%0d", d), 64'(yd[d]), 64'(0));
            check($sformatf("rst_frame_done_d%0d", d), 64'(fdv[d]), 64'(0));
            check($sformatf("rst_luma_sum_d%0d", d), 64'(lsv[d]), 64'(0));
            return;
        end
        fdx = (cyc == fd_cyc[d]);
        if (fdx) mlsum[d] = lexp[d];
        check($sformatf("frame_done_d%0d", d), 64'(fdv[d]), 64'(fdx));
        check($sformatf("luma_sum_d%0d", d), 64'(lsv[d]), 64'(mlsum[d]));
        if (fdv[d]) fd_cnt[d]++;
        if (yv[d] && yr[d]) begin
            check($sformatf("scoreboard_has_entry_d%0d", d),
                  64'((d == 0) ? (q0.size() > 0) : (q1.size() > 0)), 64'(1));
            if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("y_data_d%0d_c%0d_r%0d", d, e.col, e.row), 64'(yd[d]), 64'(e.data));
                if (d == 0 && e.row == 2 && (e.col == 1 || e.col == 2 || e.col == 317 || e.col == 318)) begin
                    cexp = (e.col == 2 || e.col == 317) ? 30'h20080200 : 30'h0;
                    check($sformatf("corner_c%0d_r2", e.col), 64'(yd[d]), 64'(cexp));
                    corner_hits++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) in_mon(d);
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) out_mon(d);
    end

    task automatic run_big();
        int n = 0;
        int t = 0;
        rst_b = 1'b0; xb.valid = 1'b0; xb.data = '0; yb.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        check("big_ready_after_reset", 64'(xb.ready), 64'(1));
        @(posedge clk); #1;
        xb.valid = 1'b1;
        xb.data  = pix(8'h80, 8'h80, 8'h80);
        while (n < 76800 && t < 80000) begin
            @(negedge clk);
            t++;
            if (xb.ready) n++;
        end
        @(posedge clk); #1;
        xb.valid = 1'b0;
        check("big_beats_accepted", 64'(n), 64'(76800));
        repeat (4) @(negedge clk);
        check("big_frame_done_count", 64'(fd_cnt[0]), 64'(1));
        check("big_luma_sum", 64'(ls_b), 64'(9545728));
        check("big_corner_hits", 64'(corner_hits), 64'(4));
        check("big_queue_drained", 64'(q0.size()), 64'(0));
    endtask

    task automatic feed(input int n, input int mode, input bit rnd);
        int k = 0;
        int t = 0;
        xs.valid = 1'b1;
        xs.data  = gen(mode, rk);
        if (rnd) ys.ready = 1'($urandom_range(0, 1));
        while (k < n && t < 4000) begin
            @(negedge clk);
            t++;
            if (xs.ready) begin k++; rk++; end
            @(posedge clk); #1;
            xs.data = gen(mode, rk);
            if (rnd) ys.ready = 1'($urandom_range(0, 1));
        end
        xs.valid = 1'b0;
        ys.ready = 1'b1;
        check($sformatf("feed_mode%0d_beats", mode), 64'(k), 64'(n));
    endtask

    task automatic run_sml();
        int          a0, n, t;
        bit          have, full, seen;
        logic [29:0] ref_d;
        rst_s = 1'b0; xs.valid = 1'b0; xs.data = '0; ys.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_s = 1'b1;
        @(negedge clk);
        check("sml_ready_after_reset", 64'(xs.ready), 64'(1));
        @(posedge clk); #1;

        // Stalled output: only two beats may enter, head must not move.
        a0 = acc_cnt[1]; have = 0; ref_d = '0;
        xs.valid = 1'b1; ys.ready = 1'b0; xs.data = gen(0, rk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ys.valid) begin
                if (!have) begin have = 1; ref_d = ys.data; end
                else check("hold_y_stable", 64'(ys.data), 64'(ref_d));
            end
            if (xs.ready) rk++;
            @(posedge clk); #1;
            xs.data = gen(0, rk);
        end
        xs.valid = 1'b0;
        check("hold_accepts", 64'(acc_cnt[1] - a0), 64'(2));
        check("hold_head_is_fill", 64'(ref_d), 64'(SFILL));

        feed(SW * SH - 2, 0, 1'b1);
        feed(SW * SH, 1, 1'b0);
        @(negedge clk);
        check("sml_luma_all_ff", 64'(ls_s), 64'(24480));
        @(posedge clk); #1;
        feed(SW * SH, 2, 1'b0);
        @(negedge clk);
        check("sml_luma_all_00", 64'(ls_s), 64'(0));
        @(posedge clk); #1;
        check("sml_frame_done_count", 64'(fd_cnt[1]), 64'(3));

        // Mid-frame reset with the FIFO full.
        feed(100, 0, 1'b0);
        ys.ready = 1'b0; xs.valid = 1'b1; xs.data = gen(0, rk);
        full = 0; t = 0;
        while (!full && t < 10) begin
            @(negedge clk);
            t++;
            if (!xs.ready) full = 1;
            else begin
                rk++;
                @(posedge clk); #1;
                xs.data = gen(0, rk);
            end
        end
        check("fifo_full_before_reset", 64'(full), 64'(1));
        @(posedge clk);
        #2 rst_s = 1'b0;
        #1;
        check("y_valid_drops_on_reset", 64'(ys.valid), 64'(0));
        xs.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_s = 1'b1;
        ys.ready = 1'b1; xs.valid = 1'b1; xs.data = gen(0, rk);
        n = 0; t = 0; seen = 0;
        while (!seen && t < 1000) begin
            @(negedge clk);
            t++;
            if (fd_s) seen = 1;
            else begin
                if (xs.ready) begin n++; rk++; end
                @(posedge clk); #1;
                xs.data = gen(0, rk);
            end
        end
        @(posedge clk); #1;
        xs.valid = 1'b0;
        check("frame_done_after_reset_seen", 64'(seen), 64'(1));
        check("beats_to_frame_done", 64'(n), 64'(SW * SH));
        repeat (5) @(posedge clk);
        #1;
        check("sml_queue_drained", 64'(q1.size()), 64'(0));
    endtask

    initial begin
        #960000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            mcol[d] = 0; mrow[d] = 0; macc[d] = 0; mlsum[d] = 0; lexp[d] = 0;
            occ[d] = 0; acc_cnt[d] = 0; fd_cnt[d] = 0; fd_cyc[d] = -1;
        end
        fork
            run_big();
            run_sml();
        join
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
